bus_arb: RTL

//  Two-master arbiter for the 22-bit word-addressed RISC5 system bus. M0 is the CPU
//  bus interface; M1 is a DMA/display-refresh master. Grants the shared bus to one

---
 rtl/bus_arb.sv | 137 +++++++++++++
 1 files changed

// File: rtl/bus_arb.sv
// Two-master arbiter for the 22-bit word-addressed RISC5 system bus.
// It holds the grant across locked read-modify-write sequences and aborts transactions that never receive bus_ack.
module bus_arb #(
  parameter bit          RR      = 1'b1,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_stb,
  input  logic        m0_we,
  input  logic        m0_lock,
  input  logic [21:0] m0_addr,
  input  logic [31:0] m0_dout,
  output logic [31:0] m0_din,
  output logic        m0_ack,
  output logic        m0_err,
  input  logic        m1_stb,
  input  logic        m1_we,
  input  logic        m1_lock,
  input  logic [21:0] m1_addr,
  input  logic [31:0] m1_dout,
  output logic [31:0] m1_din,
  output logic        m1_ack,
  output logic        m1_err,
  output logic        bus_stb,
  output logic        bus_we,
  output logic [21:0] bus_addr,
  output logic [31:0] bus_dout,
  input  logic [31:0] bus_din,
  input  logic        bus_ack,
  output logic [1:0]  gnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  localparam logic [15:0] TIMER_LAST = (TIMEOUT == 0) ? 16'hFFFF : 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        last_owner_q, last_owner_d;
  logic [15:0] timer_q, timer_d;

  logic own;
  logic own_m1;
  logic sel_stb;
  logic sel_lock;
  logic timeout;

  assign own      = (state_q == OWN0) || (state_q == OWN1);
  assign own_m1   = (state_q == OWN1);
  assign sel_stb  = own_m1 ? m1_stb  : m0_stb;
  assign sel_lock = own_m1 ? m1_lock : m0_lock;
  // A slave ack in the final watchdog cycle is a normal completion, so it masks the abort.
  assign timeout  = own && sel_stb && (TIMEOUT != 0) && (timer_q == TIMER_LAST) && !bus_ack;

  // last_owner_q = 1 means M1 was served last, so M0 wins the first contention after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      timer_q      <= timer_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    timer_d      = '0;
    case (state_q)
      IDLE: begin
        if (m0_stb && m1_stb)
          state_d = (RR && !last_owner_q) ? OWN1 : OWN0;
        else if (m0_stb)
          state_d = OWN0;
        else if (m1_stb)
          state_d = OWN1;
      end
      OWN0, OWN1: begin
        if (!sel_stb) begin
          state_d = IDLE;
        end else if (bus_ack) begin
          last_owner_d = own_m1;
          state_d      = sel_lock ? state_q : IDLE;
        end else if (timeout) begin
          last_owner_d = own_m1;
          state_d      = IDLE;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt      = {state_q == OWN1, state_q == OWN0};
    bus_stb  = 1'b0;
    bus_we   = 1'b0;
    bus_addr = '0;
    bus_dout = '0;
    m0_din   = '0;
    m0_ack   = 1'b0;
    m0_err   = 1'b0;
    m1_din   = '0;
    m1_ack   = 1'b0;
    m1_err   = 1'b0;
    case (state_q)
      OWN0: begin
        bus_stb  = m0_stb && !timeout;
        bus_we   = m0_we;
        bus_addr = m0_addr;
        bus_dout = m0_dout;
        m0_ack   = bus_ack || timeout;
        m0_err   = timeout;
        m0_din   = timeout ? 32'd0 : bus_din;
      end
      OWN1: begin
        bus_stb  = m1_stb && !timeout;
        bus_we   = m1_we;
        bus_addr = m1_addr;
        bus_dout = m1_dout;
        m1_ack   = bus_ack || timeout;
        m1_err   = timeout;
        m1_din   = timeout ? 32'd0 : bus_din;
      end
      default: ;
    endcase
  end

endmodule
